// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter
// Shares one fpnew-style FPU master port between NB_CORES core slave ports.
// - Round-robin arbitration with zero-cycle latency. The pointer rr_q only
//   advances on a handshake, so a stalled winner keeps its priority.
// - The granted core ID of every accepted op is written to an in-order ID FIFO.
//   Each in-order FPU response is routed back to the core at the FIFO head.
// - Result data and flags are broadcast to all cores. Only the rvalid strobe
//   is steered.
// - A response that arrives while nothing is outstanding is dropped and sets a
//   sticky error flag.
// Optional feature: define FPU_RR_ARBITER_STALL_CNT_EN to add stall_cnt_o.
// It is a saturating 32-bit count of cycles in which some core requested but
// no handshake happened.

module fpu_rr_arbiter #(
    parameter int NB_CORES      = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int NB_ARGS       = 3,
    parameter int OPCODE_WIDTH  = 6,
    parameter int DSFLAGS_WIDTH = 15,
    parameter int USFLAGS_WIDTH = 5,
    parameter int MAX_INFLIGHT  = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NB_CORES-1:0]                        core_req_i,
    output logic [NB_CORES-1:0]                        core_gnt_o,
    input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0]     core_operands_i,
    input  logic [NB_CORES*OPCODE_WIDTH-1:0]           core_op_i,
    input  logic [NB_CORES*DSFLAGS_WIDTH-1:0]          core_flags_i,
    output logic [NB_CORES-1:0]                        core_rvalid_o,
    output logic [DATA_WIDTH-1:0]                      core_rdata_o,
    output logic [USFLAGS_WIDTH-1:0]                   core_rflags_o,
    output logic                                       fpu_req_o,
    input  logic                                       fpu_gnt_i,
    output logic [NB_ARGS*DATA_WIDTH-1:0]              fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                    fpu_op_o,
    output logic [DSFLAGS_WIDTH-1:0]                   fpu_flags_o,
    output logic                                       fpu_rready_o,
    input  logic                                       fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                      fpu_rdata_i,
    input  logic [USFLAGS_WIDTH-1:0]                   fpu_rflags_i,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]          inflight_o,
    output logic                                       err_o
`ifdef FPU_RR_ARBITER_STALL_CNT_EN
    ,
    output logic [31:0]                                stall_cnt_o
`endif
);

    localparam int CORE_W = $clog2(NB_CORES);
    localparam int PTR_W  = $clog2(MAX_INFLIGHT);
    localparam int CNT_W  = $clog2(MAX_INFLIGHT+1);
    localparam int OPS_W  = NB_ARGS*DATA_WIDTH;

    // Round-robin pointer, ID FIFO state and sticky error
    logic [CORE_W-1:0] rr_q,      rr_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              err_q,     err_d;
    logic [CORE_W-1:0] id_fifo_q [MAX_INFLIGHT];
    logic [CORE_W-1:0] id_fifo_d [MAX_INFLIGHT];

    // Combinational arbitration/response signals
    logic [CORE_W-1:0] winner_s;
    logic              any_req_s;
    logic              full_s;
    logic              req_s;
    logic              hs_s;
    logic              pop_s;
    logic [CORE_W-1:0] head_s;
    logic [NB_CORES-1:0] gnt_s;
    logic [NB_CORES-1:0] rvalid_s;

    // Winner search: first requester at or above rr_q, wrapping modulo NB_CORES.
    // Core 0 is selected when nobody requests.
    always_comb begin
        logic              found;
        logic [CORE_W:0]   sum;
        logic [CORE_W-1:0] idx;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        winner_s = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            sum = {1'b0, rr_q} + (CORE_W+1)'(k);
            if (sum >= (CORE_W+1)'(NB_CORES)) begin
                sum = sum - (CORE_W+1)'(NB_CORES);
            end else begin
                sum = sum;
            end
            idx = sum[CORE_W-1:0];
            if (!found && core_req_i[idx]) begin
                winner_s = idx;
                found    = 1'b1;
            end else begin
                found    = found;
            end
        end
    end

    // Request/handshake qualification.
    // full uses the registered count, so a pop in the same cycle does not reopen the port.
    always_comb begin
        any_req_s = |core_req_i;
        full_s    = (count_q == CNT_W'(MAX_INFLIGHT));
        req_s     = any_req_s & ~full_s;
        hs_s      = req_s & fpu_gnt_i;
        pop_s     = fpu_rvalid_i & (count_q != '0);
        head_s    = id_fifo_q[rd_ptr_q];
    end

    // Payload mux toward the FPU, plus one-hot grant and rvalid steering back to the cores
    always_comb begin
        fpu_operands_o = core_operands_i[0 +: OPS_W];
        fpu_op_o       = core_op_i[0 +: OPCODE_WIDTH];
        fpu_flags_o    = core_flags_i[0 +: DSFLAGS_WIDTH];
        gnt_s          = '0;
        rvalid_s       = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            if (winner_s == CORE_W'(i)) begin
                fpu_operands_o = core_operands_i[i*OPS_W +: OPS_W];
                fpu_op_o       = core_op_i[i*OPCODE_WIDTH +: OPCODE_WIDTH];
                fpu_flags_o    = core_flags_i[i*DSFLAGS_WIDTH +: DSFLAGS_WIDTH];
                gnt_s[i]       = hs_s;
            end else begin
                gnt_s[i]       = 1'b0;
            end
            rvalid_s[i] = pop_s & (head_s == CORE_W'(i));
        end
    end

    // Next-state for the round-robin pointer, ID FIFO, outstanding count and error flag
    always_comb begin
        rr_d      = rr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q;
        id_fifo_d = id_fifo_q;

        if (hs_s) begin
            id_fifo_d[wr_ptr_q] = winner_s;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            if (winner_s == CORE_W'(NB_CORES-1)) begin
                rr_d = '0;
            end else begin
                rr_d = winner_s + CORE_W'(1);
            end
        end else begin
            rr_d = rr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({hs_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // An orphan response means the FPU and our bookkeeping disagree
        if (fpu_rvalid_i && (count_q == '0)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with asynchronous active-high reset; FIFO contents are discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                id_fifo_q[i] <= '0;
            end
        end else begin
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                id_fifo_q[i] <= id_fifo_d[i];
            end
        end
    end

`ifdef FPU_RR_ARBITER_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles in which someone asked but nothing was accepted
    always_comb begin
        if (any_req_s && !hs_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign fpu_req_o     = req_s;
    assign core_gnt_o    = gnt_s;
    assign core_rvalid_o = rvalid_s;
    assign core_rdata_o  = fpu_rdata_i;
    assign core_rflags_o = fpu_rflags_i;
    assign fpu_rready_o  = 1'b1;
    assign inflight_o    = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Directed bench for fpu_rr_arbiter.
// Stimulus pushes the expected grants and responses into queues.
// A monitor pops and compares them whenever the DUT shows a grant or an rvalid.
module tb_fpu_rr_arbiter;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int NA = 3;
    localparam int OW = 6;
    localparam int FW = 15;
    localparam int UW = 5;
    localparam int MI = 4;

    logic                 clk;
    logic                 rst;
    logic [NC-1:0]        core_req_i;
    logic [NC-1:0]        core_gnt_o;
    logic [NC*NA*DW-1:0]  core_operands_i;
    logic [NC*OW-1:0]     core_op_i;
    logic [NC*FW-1:0]     core_flags_i;
    logic [NC-1:0]        core_rvalid_o;
    logic [DW-1:0]        core_rdata_o;
    logic [UW-1:0]        core_rflags_o;
    logic                 fpu_req_o;
    logic                 fpu_gnt_i;
    logic [NA*DW-1:0]     fpu_operands_o;
    logic [OW-1:0]        fpu_op_o;
    logic [FW-1:0]        fpu_flags_o;
    logic                 fpu_rready_o;
    logic                 fpu_rvalid_i;
    logic [DW-1:0]        fpu_rdata_i;
    logic [UW-1:0]        fpu_rflags_i;
    logic [2:0]           inflight_o;
    logic                 err_o;
`ifdef FPU_RR_ARBITER_STALL_CNT_EN
    logic [31:0]          stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int exp_gnt[$];
    int exp_rid[$];
    logic [DW-1:0] exp_rdata[$];

    fpu_rr_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .core_req_i      (core_req_i),
        .core_gnt_o      (core_gnt_o),
        .core_operands_i (core_operands_i),
        .core_op_i       (core_op_i),
        .core_flags_i    (core_flags_i),
        .core_rvalid_o   (core_rvalid_o),
        .core_rdata_o    (core_rdata_o),
        .core_rflags_o   (core_rflags_o),
        .fpu_req_o       (fpu_req_o),
        .fpu_gnt_i       (fpu_gnt_i),
        .fpu_operands_o  (fpu_operands_o),
        .fpu_op_o        (fpu_op_o),
        .fpu_flags_o     (fpu_flags_o),
        .fpu_rready_o    (fpu_rready_o),
        .fpu_rvalid_i    (fpu_rvalid_i),
        .fpu_rdata_i     (fpu_rdata_i),
        .fpu_rflags_i    (fpu_rflags_i),
        .inflight_o      (inflight_o),
`ifdef FPU_RR_ARBITER_STALL_CNT_EN
        .stall_cnt_o     (stall_cnt_o),
`endif
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NA*DW-1:0] opnds(input int c);
        logic [NA*DW-1:0] r;
        r = '0;
        for (int a = 0; a < NA; a++) r[a*DW +: DW] = 32'hA000_0000 + 32'(c*16 + a);
        return r;
    endfunction

    function automatic logic [OW-1:0] opc(input int c);
        return OW'(c + 12);
    endfunction

    function automatic logic [FW-1:0] flg(input int c);
        return FW'(c*3 + 100);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input int id, input logic [DW-1:0] d);
        fpu_rvalid_i = 1'b1;
        fpu_rdata_i  = d;
        fpu_rflags_i = d[UW-1:0];
        exp_rid.push_back(id);
        exp_rdata.push_back(d);
    endtask

    // Monitor: compares grants and responses against the scoreboard queues
    always @(negedge clk) begin
        if (!rst) begin
            if (|core_gnt_o) begin
                if (exp_gnt.size() == 0) begin
                    check("unexpected_gnt", 128'(core_gnt_o), 128'(0));
                end else begin
                    check("gnt", 128'(core_gnt_o), 128'(4'b0001 << exp_gnt.pop_front()));
                end
            end
            if (|core_rvalid_o) begin
                if (exp_rid.size() == 0) begin
                    check("unexpected_rvalid", 128'(core_rvalid_o), 128'(0));
                end else begin
                    logic [DW-1:0] d;
                    d = exp_rdata.pop_front();
                    check("rvalid", 128'(core_rvalid_o), 128'(4'b0001 << exp_rid.pop_front()));
                    check("rdata", 128'(core_rdata_o), 128'(d));
                    check("rflags", 128'(core_rflags_o), 128'(d[UW-1:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < NC; c++) begin
            core_operands_i[c*NA*DW +: NA*DW] = opnds(c);
            core_op_i[c*OW +: OW]             = opc(c);
            core_flags_i[c*FW +: FW]          = flg(c);
        end
        rst = 1'b1; core_req_i = '0; fpu_gnt_i = 1'b0;
        fpu_rvalid_i = 1'b0; fpu_rdata_i = '0; fpu_rflags_i = '0;
        tick(); tick();
        check("rst_req", 128'(fpu_req_o), 128'(0));
        check("rst_gnt", 128'(core_gnt_o), 128'(0));
        check("rst_rvalid", 128'(core_rvalid_o), 128'(0));
        check("rst_inflight", 128'(inflight_o), 128'(0));
        check("rst_err", 128'(err_o), 128'(0));
        check("rst_rready", 128'(fpu_rready_o), 128'(1));
        check("idle_op_core0", 128'(fpu_op_o), 128'(opc(0)));
        rst = 1'b0;
        tick();

        // All cores request, grant held: 0,1,2,3 then FIFO full
        core_req_i = 4'b1111; fpu_gnt_i = 1'b1;
        for (int k = 0; k < NC; k++) exp_gnt.push_back(k);
        for (int k = 0; k < NC; k++) begin
            #1 check("rr_op", 128'(fpu_op_o), 128'(opc(k)));
            tick();
        end
        #1 check("full_inflight", 128'(inflight_o), 128'(4));
        check("full_req", 128'(fpu_req_o), 128'(0));
        tick();
        respond(0, 32'h0000_00A0);
        #1 check("full_req_pop", 128'(fpu_req_o), 128'(0));
        tick();
        fpu_rvalid_i = 1'b0;
        exp_gnt.push_back(0);
        #1 check("reopen_inflight", 128'(inflight_o), 128'(3));
        check("reopen_req", 128'(fpu_req_o), 128'(1));
        tick();
        core_req_i = '0; fpu_gnt_i = 1'b0;
        respond(1, 32'h0000_00B1); tick();
        respond(2, 32'h0000_00B2); tick();
        respond(3, 32'h0000_00B3); tick();
        respond(0, 32'h0000_00B4); tick();
        fpu_rvalid_i = 1'b0;
        #1 check("drain_inflight", 128'(inflight_o), 128'(0));
        check("drain_err", 128'(err_o), 128'(0));

        // Stalled grant keeps core 0 at the front
        rst = 1'b1; tick(); rst = 1'b0; tick();
        core_req_i = 4'b1111; fpu_gnt_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 check("stall_gnt", 128'(core_gnt_o), 128'(0));
            check("stall_req", 128'(fpu_req_o), 128'(1));
            check("stall_opnds", 128'(fpu_operands_o), 128'(opnds(0)));
            check("stall_flags", 128'(fpu_flags_o), 128'(flg(0)));
            tick();
        end
        fpu_gnt_i = 1'b1; exp_gnt.push_back(0);
        tick();
        core_req_i = '0; fpu_gnt_i = 1'b0;
        respond(0, 32'h0000_0055); tick();
        fpu_rvalid_i = 1'b0;

        // Out-of-index-order grants 2,0,3 with push/pop overlap
        core_req_i = 4'b0100; fpu_gnt_i = 1'b1; exp_gnt.push_back(2); tick();
        core_req_i = 4'b0001; exp_gnt.push_back(0); tick();
        core_req_i = 4'b1000; exp_gnt.push_back(3);
        respond(2, 32'h0000_0011);
        #1 check("route_op", 128'(fpu_op_o), 128'(opc(3)));
        tick();
        core_req_i = '0; fpu_gnt_i = 1'b0;
        respond(0, 32'h0000_0022);
        #1 check("pushpop_inflight", 128'(inflight_o), 128'(2));
        tick();
        respond(3, 32'h0000_0033); tick();
        fpu_rvalid_i = 1'b0;
        #1 check("route_inflight", 128'(inflight_o), 128'(0));

        // Orphan response: dropped, sticky error until reset
        fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'h0000_0099;
        #1 check("orphan_rvalid", 128'(core_rvalid_o), 128'(0));
        check("orphan_err_pre", 128'(err_o), 128'(0));
        tick();
        fpu_rvalid_i = 1'b0;
        #1 check("orphan_err", 128'(err_o), 128'(1));
        tick(); tick(); tick();
        check("err_sticky", 128'(err_o), 128'(1));
        rst = 1'b1;
        #1 check("err_cleared", 128'(err_o), 128'(0));
        tick(); rst = 1'b0; tick();

`ifdef FPU_RR_ARBITER_STALL_CNT_EN
        core_req_i = 4'b0010; fpu_gnt_i = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        fpu_gnt_i = 1'b1; exp_gnt.push_back(1); tick();
        core_req_i = '0; fpu_gnt_i = 1'b0;
        #1 check("stall_cnt", 128'(stall_cnt_o), 128'(7));
        respond(1, 32'h0000_0077); tick();
        fpu_rvalid_i = 1'b0; tick();
        check("stall_cnt_hold", 128'(stall_cnt_o), 128'(7));
`endif

        tick();
        check("gnt_queue_empty", 128'(exp_gnt.size()), 128'(0));
        check("resp_queue_empty", 128'(exp_rid.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_rr_arbiter.md
Name: fpu_rr_arbiter

Overview:
- Shares one FPU master port (fpnew-style req/gnt request channel, rvalid response channel) between NB_CORES core slave ports.
- Round-robin arbitration with zero-cycle arbitration latency.
- Records the granted core ID of every accepted operation in an in-order ID FIFO and uses it to route each in-order FPU response back to its issuing core.
- Sits between the per-core FPU demux slaves and a single shared FPU instance in the cluster.

Parameters:
- NB_CORES, 4, number of requesting cores (≥2)
- DATA_WIDTH, 32, operand/result width
- NB_ARGS, 3, operands per request
- OPCODE_WIDTH, 6, opcode width
- DSFLAGS_WIDTH, 15, downstream flags width
- USFLAGS_WIDTH, 5, upstream (result) flags width
- MAX_INFLIGHT, 4, ID FIFO depth = max outstanding ops; power of 2, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- core_req_i  in  NB_CORES  per-core request
- core_gnt_o  out  NB_CORES  per-core grant
- core_operands_i  in  NB_CORES×NB_ARGS×DATA_WIDTH  operands
- core_op_i  in  NB_CORES×OPCODE_WIDTH  opcode
- core_flags_i  in  NB_CORES×DSFLAGS_WIDTH  flags
- core_rvalid_o  out  NB_CORES  per-core response valid
- core_rdata_o  out  DATA_WIDTH  result, broadcast to all cores
- core_rflags_o  out  USFLAGS_WIDTH  result flags, broadcast to all cores
- fpu_req_o  out  1  FPU request
- fpu_gnt_i  in  1  FPU grant
- fpu_operands_o  out  NB_ARGS×DATA_WIDTH  muxed operands
- fpu_op_o  out  OPCODE_WIDTH  muxed opcode
- fpu_flags_o  out  DSFLAGS_WIDTH  muxed flags
- fpu_rready_o  out  1  tied 1 (cores always accept responses)
- fpu_rvalid_i  in  1  FPU response valid
- fpu_rdata_i  in  DATA_WIDTH  FPU result
- fpu_rflags_i  in  USFLAGS_WIDTH  FPU result flags
- inflight_o  out  $clog2(MAX_INFLIGHT+1)  current outstanding-op count
- err_o  out  1  sticky protocol error

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset: rr_q=0, FIFO wr/rd pointers=0, count=0, err_o=0. Consequently fpu_req_o=0, all core_gnt_o=0, all core_rvalid_o=0, inflight_o=0. Payload outputs are combinational and select core 0 when no core requests.
- Arbitration (combinational):
  - Winner w = first index i with core_req_i[i]=1, scanning from rr_q upward and wrapping modulo NB_CORES.
  - full = (count == MAX_INFLIGHT).
  - fpu_req_o = |core_req_i & ~full.
  - fpu_operands_o/op/flags = core w payload.
  - core_gnt_o[w] = fpu_gnt_i & fpu_req_o; all other grants 0.
- Handshake (fpu_req_o & fpu_gnt_i):
  - Push w into the FIFO.
  - rr_q <= (w+1) mod NB_CORES; wraps from NB_CORES-1 to 0.
  - Without a handshake, rr_q holds.
- Core rules: a core holds req and payload stable until it is granted. A stalled winner keeps priority, since rr_q does not move.
- Response (fpu_rvalid_i=1, FIFO non-empty):
  - core_rvalid_o[head]=1 in the same cycle; pop the FIFO.
  - core_rdata_o/core_rflags_o are always driven from fpu_rdata_i/fpu_rflags_i.
- Response with FIFO empty (count==0 registered): no core_rvalid_o asserted, response dropped, err_o <= 1. err_o stays set until reset.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full:
  - fpu_req_o is forced 0 even when a pop occurs in the same cycle; full uses the registered count.
  - Request acceptance resumes the cycle after count drops.
- A response is never matched to an op granted in the same cycle. The FPU has ≥1 cycle latency.
- Count arithmetic:
  - count_n = count + push − pop, never outside 0..MAX_INFLIGHT.
  - Pointers are $clog2(MAX_INFLIGHT) bits and wrap naturally.
  - inflight_o = count.
- Reset mid-operation: FIFO contents are discarded. FPU responses arriving after reset for pre-reset ops set err_o.

Optional Feature:
- Macro FPU_RR_ARBITER_STALL_CNT_EN.
- When defined, add port stall_cnt_o out 32, plus a register that increments each cycle with |core_req_i=1 and no handshake. It saturates at 0xFFFF_FFFF and resets to 0.
- When undefined, neither the port nor the register exists; behaviour is otherwise identical.

Test Plan:
- Reset, then cores 0,1,2,3 all request with fpu_gnt_i=1 held → grants go to cores 0,1,2,3 on cycles 1–4, one per cycle; rr_q returns to 0.
- All 4 cores request with fpu_gnt_i=0 for 5 cycles → core_gnt_o=0, rr_q stays 0, fpu payload = core 0; gnt=1 → core 0 granted.
- 4 ops accepted, no rvalid → inflight_o=4, fpu_req_o=0 despite requests; one rvalid → the following cycle fpu_req_o=1 again.
- Grants in order core2, core0, core3; three rvalids with rdata 0x11,0x22,0x33 → core_rvalid_o pulses 0b0100, 0b0001, 0b1000 in order with matching rdata.
- fpu_rvalid_i=1 with inflight_o=0 → no core_rvalid_o, err_o=1 and it stays 1 until rst pulse.
- With FPU_RR_ARBITER_STALL_CNT_EN, core1 requests with gnt=0 for 7 cycles then is granted → stall_cnt_o=7.
